// File: rtl/sdf_twiddle_gen.sv
// rtl/sdf_twiddle_gen.sv - twiddle generator for one radix-2 SDF FFT/IFFT stage
// Quarter-wave cosine ROM plus symmetry, two-stage registered pipeline.
module sdf_twiddle_gen #(
    parameter int N_POINTS = 32,
    parameter int SPAN     = 16,
    parameter int DATA_W   = 22,
    parameter int FRAC_W   = 6
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic                              frame_start,
    input  logic                              inverse,
    output logic                              tw_valid,
    output logic signed [DATA_W-1:0]          tw_re,
    output logic signed [DATA_W-1:0]          tw_im,
    output logic [$clog2(N_POINTS/2)-1:0]     tw_idx,
    output logic                              bf_half,
    output logic                              frame_last
);
    localparam int  Q      = N_POINTS / 4;
    localparam int  STRIDE = N_POINTS / (2 * SPAN);
    localparam int  P_W    = $clog2(2 * SPAN);
    localparam int  M_W    = $clog2(N_POINTS / 2);
    localparam int  A_W    = $clog2(Q + 1);
    localparam int  CW     = FRAC_W + 2;
    localparam real PI     = 3.14159265358979323846;

    if (N_POINTS < 8 || (N_POINTS & (N_POINTS - 1)) != 0) begin : g_bad_n
        $error("sdf_twiddle_gen: N_POINTS must be a power of 2 and >= 8");
    end
    if (SPAN < 1 || SPAN > N_POINTS / 2 || (SPAN & (SPAN - 1)) != 0) begin : g_bad_span
        $error("sdf_twiddle_gen: SPAN must be a power of 2 in [1, N_POINTS/2]");
    end
    if (FRAC_W < 1 || DATA_W < CW) begin : g_bad_width
        $error("sdf_twiddle_gen: need FRAC_W >= 1 and DATA_W >= FRAC_W+2");
    end

    // Quarter-wave cosine table, rounded half away from zero at elaboration.
    logic signed [CW-1:0] rom [0:Q];
    for (genvar i = 0; i <= Q; i++) begin : g_rom
        localparam real CR = $cos(2.0 * PI * i / N_POINTS) * (2.0 ** FRAC_W);
        localparam int  CI = (CR >= 0.0) ? $rtoi(CR + 0.5) : -$rtoi(0.5 - CR);
        assign rom[i] = CW'(CI);
    end

    logic [P_W-1:0]          p_q, p_d, p_cur;
    logic                    v1_q, inv1_q, h1_q, l1_q;
    logic [M_W-1:0]          m1_q, m1_d;
    logic                    h1_d, l1_d;
    int                      m_full;

    logic                    v2_q, h2_q, l2_q;
    logic signed [DATA_W-1:0] re_q, im_q;
    logic [M_W-1:0]          m2_q;

    always_comb begin
        p_cur  = frame_start ? '0 : p_q;
        p_d    = p_q;
        if (in_valid) begin
            p_d = (p_cur == P_W'(2 * SPAN - 1)) ? '0 : p_cur + 1'b1;
        end
        h1_d   = (int'(p_cur) >= SPAN);
        l1_d   = (int'(p_cur) == 2 * SPAN - 1);
        m_full = (int'(p_cur) - SPAN) * STRIDE;
        m1_d   = h1_d ? M_W'(m_full) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q    <= '0;
            v1_q   <= 1'b0;
            m1_q   <= '0;
            inv1_q <= 1'b0;
            h1_q   <= 1'b0;
            l1_q   <= 1'b0;
        end else begin
            p_q  <= p_d;
            v1_q <= in_valid;
            if (in_valid) begin
                m1_q   <= m1_d;
                inv1_q <= inverse;
                h1_q   <= h1_d;
                l1_q   <= l1_d;
            end
        end
    end

    // Fold m onto the first quadrant: second-quadrant angles mirror around pi/2.
    int                   m_i;
    logic [A_W-1:0]       a_re, a_im;
    logic                 neg_re;
    logic signed [CW-1:0] c_re, c_im, re_s, im_s;

    always_comb begin
        m_i = int'(m1_q);
        if (m_i <= Q) begin
            a_re   = A_W'(m_i);
            a_im   = A_W'(Q - m_i);
            neg_re = 1'b0;
        end else begin
            a_re   = A_W'(2 * Q - m_i);
            a_im   = A_W'(m_i - Q);
            neg_re = 1'b1;
        end
        c_re = rom[a_re];
        c_im = rom[a_im];
        re_s = neg_re ? -c_re : c_re;
        im_s = inv1_q ? c_im : -c_im;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q <= 1'b0;
            re_q <= '0;
            im_q <= '0;
            m2_q <= '0;
            h2_q <= 1'b0;
            l2_q <= 1'b0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                re_q <= DATA_W'(re_s);
                im_q <= DATA_W'(im_s);
                m2_q <= m1_q;
                h2_q <= h1_q;
                l2_q <= l1_q;
            end
        end
    end

    assign tw_valid   = v2_q;
    assign tw_re      = re_q;
    assign tw_im      = im_q;
    assign tw_idx     = m2_q;
    assign bf_half    = h2_q;
    assign frame_last = l2_q;
endmodule

// File: tb/tb_sdf_twiddle_gen.sv
// tb/tb_sdf_twiddle_gen.sv - scoreboard bench for sdf_twiddle_gen over several N/SPAN configurations
module tb_sdf_twiddle_gen;
    localparam int  NC = 5;
    localparam int  NS [NC] = '{32, 32, 8, 8, 256};
    localparam int  LS [NC] = '{16, 4, 1, 4, 32};
    localparam real PI = 3.14159265358979323846;

    typedef struct {
        int     re;
        int     im;
        int     idx;
        bit     half;
        bit     last;
        bit     inv;
        longint due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic frame_start = 1'b0;
    logic inverse = 1'b0;
    longint cyc = 0;
    bit done = 1'b0;

    logic              o_v   [NC];
    logic signed [21:0] o_re [NC];
    logic signed [21:0] o_im [NC];
    logic [7:0]        o_idx [NC];
    logic              o_h   [NC];
    logic              o_l   [NC];

    exp_t sb [NC][$];
    int   pos [NC];
    int   lre [NC], lim [NC], lidx [NC];
    bit   lh [NC], ll [NC];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NC; g++) begin : g_dut
        localparam int MW = $clog2(NS[g] / 2);
        logic [MW-1:0]      idx;
        logic signed [21:0] re, im;
        logic               v, h, l;
        sdf_twiddle_gen #(.N_POINTS(NS[g]), .SPAN(LS[g]), .DATA_W(22), .FRAC_W(6)) u_dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .frame_start(frame_start),
            .inverse(inverse), .tw_valid(v), .tw_re(re), .tw_im(im), .tw_idx(idx),
            .bf_half(h), .frame_last(l)
        );
        assign o_v[g]   = v;
        assign o_re[g]  = re;
        assign o_im[g]  = im;
        assign o_idx[g] = 8'(idx);
        assign o_h[g]   = h;
        assign o_l[g]   = l;
    end

    function automatic int rnd(real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    function automatic exp_t model(int n, int l, int p, bit inv, longint due);
        exp_t e;
        real  th;
        e.half = (p >= l);
        e.last = (p == 2 * l - 1);
        e.idx  = e.half ? (p - l) * (n / (2 * l)) : 0;
        th     = 2.0 * PI * e.idx / n;
        e.re   = rnd($cos(th) * 64.0);
        e.im   = -rnd($sin(th) * 64.0);
        if (inv) e.im = -e.im;
        e.inv  = inv;
        e.due  = due;
        return e;
    endfunction

    task automatic chk(string nm, int g, longint act, longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d: got %0d expected %0d", nm, g, cyc, act, req);
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < NC; g++) begin
            if (rst) begin
                chk("rst_valid", g, o_v[g], 0);
                chk("rst_re", g, o_re[g], 0);
                chk("rst_im", g, o_im[g], 0);
                chk("rst_idx", g, o_idx[g], 0);
                chk("rst_half", g, o_h[g], 0);
                chk("rst_last", g, o_l[g], 0);
                sb[g].delete();
                lre[g] = 0; lim[g] = 0; lidx[g] = 0; lh[g] = 0; ll[g] = 0;
            end else if (o_v[g]) begin
                if (sb[g].size() == 0) begin
                    chk("spurious_valid", g, 1, 0);
                end else begin
                    exp_t e;
                    e = sb[g].pop_front();
                    chk("latency", g, cyc, e.due);
                    chk("re", g, o_re[g], e.re);
                    chk("im", g, o_im[g], e.im);
                    chk("idx", g, o_idx[g], e.idx);
                    chk("half", g, o_h[g], e.half);
                    chk("last", g, o_l[g], e.last);
                    if (g == 0) begin
                        int kr, ks;
                        bit known;
                        known = 1'b1;
                        case (e.idx)
                            0:  begin kr = 64;  ks = 0;  end
                            1:  begin kr = 63;  ks = 12; end
                            4:  begin kr = 45;  ks = 45; end
                            8:  begin kr = 0;   ks = 64; end
                            12: begin kr = -45; ks = 45; end
                            15: begin kr = -63; ks = 12; end
                            default: begin kr = 0; ks = 0; known = 1'b0; end
                        endcase
                        if (known) begin
                            chk("known_re", g, o_re[g], kr);
                            chk("known_im", g, o_im[g], e.inv ? ks : -ks);
                        end
                    end
                    lre[g] = e.re; lim[g] = e.im; lidx[g] = e.idx; lh[g] = e.half; ll[g] = e.last;
                end
            end else begin
                if (sb[g].size() > 0 && sb[g][0].due <= cyc) begin
                    chk("missing_valid", g, 0, 1);
                    void'(sb[g].pop_front());
                end
                chk("hold_re", g, o_re[g], lre[g]);
                chk("hold_im", g, o_im[g], lim[g]);
                chk("hold_idx", g, o_idx[g], lidx[g]);
                chk("hold_flags", g, {o_h[g], o_l[g]}, {lh[g], ll[g]});
            end
        end
        if (done) begin
            for (int g = 0; g < NC; g++) chk("drained", g, sb[g].size(), 0);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    task automatic issue(bit v, bit fs, bit inv);
        @(posedge clk);
        #1;
        in_valid    = v;
        frame_start = fs;
        inverse     = inv;
        if (v) begin
            for (int g = 0; g < NC; g++) begin
                int p;
                p = fs ? 0 : pos[g];
                sb[g].push_back(model(NS[g], LS[g], p, inv, cyc + 2));
                pos[g] = (p + 1) % (2 * LS[g]);
            end
        end
    endtask

    initial begin
        for (int g = 0; g < NC; g++) pos[g] = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 64; i++) issue(1'b1, i == 0, 1'b0);
        for (int i = 0; i < 64; i++) issue(1'b1, i == 0, 1'b1);
        issue(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) issue(1'b1, i == 0 || i == 10, 1'b0);
        for (int i = 0; i < 400; i++)
            issue($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 21; i++) issue(1'b1, i == 0, 1'b0);
        #3 rst = 1'b1;
        in_valid = 1'b0;
        frame_start = 1'b0;
        for (int g = 0; g < NC; g++) pos[g] = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 80; i++)
            issue($urandom_range(0, 3) != 0, 1'b0, 1'($urandom_range(0, 1)));
        issue(1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1 done = 1'b1;
        repeat (10) @(posedge clk);
        $display("FAIL timeout: monitor did not finish");
        $fatal(1);
    end
endmodule
